// File: rtl/aurora_pkg.sv
// Shared Aurora types: channel-init phase codes, per-lane encoder selects,
// and a small constant helper used to size counters.
package aurora_pkg;

  localparam int INIT_STATE_W = 3;
  localparam int TX_SEL_W     = 3;

  typedef enum logic [INIT_STATE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_ALIGN  = 3'd1,
    ST_BOND   = 3'd2,
    ST_VERIFY = 3'd3,
    ST_READY  = 3'd4
  } init_state_t;

  typedef enum logic [TX_SEL_W-1:0] {
    TX_OFF    = 3'd0,
    TX_INIT   = 3'd1,
    TX_BOND   = 3'd2,
    TX_VERIFY = 3'd3,
    TX_DATA   = 3'd4
  } tx_sel_t;

  // Largest of three integers, used for counter width elaboration
  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/aurora_lane_mask.sv
// Effective lane mask: either the raw lane_select or, in single-lane mode,
// only its lowest set bit. Also flags whether more than one lane remains.
module aurora_lane_mask
  import aurora_pkg::*;
#(
  parameter int MAX_LINKS = 2
) (
  input  logic                 single_lane_i,
  input  logic [MAX_LINKS-1:0] lane_select_i,
  output logic [MAX_LINKS-1:0] eff_mask_o,
  output logic                 multi_lane_o
);

  // x & -x isolates the lowest set bit; x & (x-1) is nonzero iff >1 bit set
  always_comb begin
    eff_mask_o = lane_select_i;
    if (single_lane_i) begin
      eff_mask_o = lane_select_i & (~lane_select_i + MAX_LINKS'(1));
    end
    multi_lane_o = ((eff_mask_o & (eff_mask_o - MAX_LINKS'(1))) != '0);
  end

endmodule

// File: rtl/aurora_channel_init_ctrl.sv
// Simplex TX channel-initialisation sequencer: RESET -> ALIGN -> (BOND) ->
// VERIFY -> READY, driven by the receiver sideband flags.
// Optional per-phase watchdog enabled by defining AURORA_INIT_WATCHDOG_EN.
module aurora_channel_init_ctrl
  import aurora_pkg::*;
#(
  parameter int MAX_LINKS    = 2,
  parameter int RESET_HOLD   = 16,
  parameter int VERIFY_MIN   = 64,
  parameter int INIT_TIMEOUT = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          single_lane,
  input  logic [MAX_LINKS-1:0]          lane_select,
  input  logic                          simplex_aligned,
  input  logic                          simplex_bonded,
  input  logic                          simplex_verified,
  input  logic                          simplex_reset,
  output logic [MAX_LINKS*TX_SEL_W-1:0] lane_tx_sel,
  output logic [MAX_LINKS-1:0]          lane_active,
  output logic                          channel_init_finished,
  output logic                          axi_ready,
  output logic [INIT_STATE_W-1:0]       init_state,
  output logic                          init_timeout
);

  localparam int CNT_W = $clog2(maxOf3(RESET_HOLD, VERIFY_MIN, INIT_TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] VERIFY_LAST = CNT_W'(VERIFY_MIN - 1);
  localparam logic [CNT_W-1:0] VERIFY_SAT  = CNT_W'(VERIFY_MIN);

  localparam logic [INIT_STATE_W-1:0] S_RESET  = ST_RESET;
  localparam logic [INIT_STATE_W-1:0] S_ALIGN  = ST_ALIGN;
  localparam logic [INIT_STATE_W-1:0] S_BOND   = ST_BOND;
  localparam logic [INIT_STATE_W-1:0] S_VERIFY = ST_VERIFY;
  localparam logic [INIT_STATE_W-1:0] S_READY  = ST_READY;

  logic [INIT_STATE_W-1:0]       state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [MAX_LINKS-1:0]          laneActive_q, laneActive_d;
  logic                          multiLane_q, multiLane_d;
  logic [MAX_LINKS*TX_SEL_W-1:0] txSel_q, txSel_d;
  logic                          finished_q;
  logic [TX_SEL_W-1:0]           selCode;
  logic [MAX_LINKS-1:0]          effMask;
  logic                          effMulti;

  aurora_lane_mask #(
    .MAX_LINKS(MAX_LINKS)
  ) u_lane_mask (
    .single_lane_i(single_lane),
    .lane_select_i(lane_select),
    .eff_mask_o   (effMask),
    .multi_lane_o (effMulti)
  );

`ifdef AURORA_INIT_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(INIT_TIMEOUT - 1);

  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             seen_q, seen_d;
  logic             timeout_q;
  logic             inPhase;
  logic             wdogExpire;

  // Watchdog fires on the last allowed cycle of a waiting phase; VERIFY is
  // exempt once the receiver has reported verification at least once
  always_comb begin
    inPhase    = (state_q == S_ALIGN) || (state_q == S_BOND) || (state_q == S_VERIFY);
    wdogExpire = inPhase && (wdog_q == TIMEOUT_LAST) &&
                 !((state_q == S_VERIFY) && (seen_q || simplex_verified));
  end

  // Phase age and verified-seen flag restart on every state change
  always_comb begin
    wdog_d = wdog_q;
    seen_d = seen_q;
    if ((state_d != state_q) || simplex_reset) begin
      wdog_d = '0;
      seen_d = 1'b0;
    end else if (inPhase) begin
      wdog_d = wdog_q + CNT_W'(1);
      if ((state_q == S_VERIFY) && simplex_verified) seen_d = 1'b1;
    end
  end

  // Watchdog registers; the timeout pulse is suppressed by a channel restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      seen_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      seen_q    <= seen_d;
      timeout_q <= wdogExpire && !simplex_reset;
    end
  end

  assign init_timeout = timeout_q;
`else
  assign init_timeout = 1'b0;
`endif

  // Phase sequencing with restart > watchdog > normal transitions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RESET: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (effMask != '0) state_d = S_ALIGN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ALIGN: begin
        if (simplex_aligned) state_d = multiLane_q ? S_BOND : S_VERIFY;
      end
      S_BOND: begin
        if (!simplex_aligned)    state_d = S_RESET;
        else if (simplex_bonded) state_d = S_VERIFY;
      end
      S_VERIFY: begin
        if (cnt_q != VERIFY_SAT) cnt_d = cnt_q + CNT_W'(1);
        if (!simplex_aligned) begin
          state_d = S_RESET;
        end else if (simplex_verified && (cnt_q >= VERIFY_LAST)) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (!simplex_aligned || !simplex_verified) state_d = S_RESET;
      end
      default: state_d = S_RESET;
    endcase
`ifdef AURORA_INIT_WATCHDOG_EN
    if (wdogExpire) state_d = S_RESET;
`endif
    if (state_d != state_q) cnt_d = '0;
    if (simplex_reset) begin
      state_d = S_RESET;
      cnt_d   = '0;
    end
  end

  // Lane configuration latches on RESET->ALIGN; outputs follow the next state
  always_comb begin
    laneActive_d = laneActive_q;
    multiLane_d  = multiLane_q;
    if (state_d == S_RESET) begin
      laneActive_d = '0;
      multiLane_d  = 1'b0;
    end else if (state_q == S_RESET) begin
      laneActive_d = effMask;
      multiLane_d  = effMulti;
    end
    case (state_d)
      S_ALIGN:  selCode = TX_INIT;
      S_BOND:   selCode = TX_BOND;
      S_VERIFY: selCode = TX_VERIFY;
      S_READY:  selCode = TX_DATA;
      default:  selCode = TX_OFF;
    endcase
    txSel_d = '0;
    for (int i = 0; i < MAX_LINKS; i++) begin
      txSel_d[i*TX_SEL_W +: TX_SEL_W] = laneActive_d[i] ? selCode : TX_OFF;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RESET;
      cnt_q        <= '0;
      laneActive_q <= '0;
      multiLane_q  <= 1'b0;
      txSel_q      <= '0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      laneActive_q <= laneActive_d;
      multiLane_q  <= multiLane_d;
      txSel_q      <= txSel_d;
      finished_q   <= (state_d == S_READY);
    end
  end

  assign lane_tx_sel           = txSel_q;
  assign lane_active           = laneActive_q;
  assign channel_init_finished = finished_q;
  assign axi_ready             = finished_q;
  assign init_state            = state_q;

endmodule

// File: doc/aurora_channel_init_ctrl.md
Name: aurora_channel_init_ctrl

Overview:
- Simplex TX channel-initialisation sequencer for the Aurora transmitter.
- Drives per-lane ordered-set selection (init / bond / verify / data) into the lane encoders.
- Walks through reset, align, bond and verify phases using the receiver sideband flags (simplex_aligned/bonded/verified/reset).
- Asserts channel_init_finished and axi_ready only once the channel is usable. Sits between the top-level control inputs and the per-lane encoder datapath.

Parameters:
- MAX_LINKS, 2: number of physical lanes (matches aurora_pkg).
- RESET_HOLD, 16: cycles spent in RESET before ALIGN (min 1).
- VERIFY_MIN, 64: minimum verification sequences sent before READY may be entered.
- INIT_TIMEOUT, 4096: per-phase timeout in cycles (used only with the watchdog feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- single_lane  in  1  force single-lane operation.
- lane_select  in  MAX_LINKS  lane enable mask.
- simplex_aligned  in  1  RX reports lanes aligned.
- simplex_bonded  in  1  RX reports lanes bonded.
- simplex_verified  in  1  RX reports channel verified.
- simplex_reset  in  1  RX requests a channel restart.
- lane_tx_sel  out  MAX_LINKS x 3  per-lane tx_sel_t selecting the encoder input.
- lane_active  out  MAX_LINKS  latched active-lane mask.
- channel_init_finished  out  1  channel up.
- axi_ready  out  1  AXI source may transfer.
- init_state  out  3  current init_state_t, for debug.
- init_timeout  out  1  one-cycle pulse on watchdog expiry; tied 0 when the feature is absent.

Behaviour:
- Clocking/reset: one clock domain; all sideband inputs are synchronous to clk.
- Reset values (rst_n=0): state RESET, counters 0, lane_tx_sel all TX_OFF, lane_active 0, channel_init_finished 0, axi_ready 0, init_timeout 0.
- Outputs are registered, so they reflect the new state in the cycle after the transition.
- Global priority, highest first:
  1. simplex_reset=1 → RESET on the next edge, from any state, including mid-phase.
  2. Watchdog expiry.
  3. Phase transitions.
- RESET:
  - lane_tx_sel = TX_OFF; the hold counter counts RESET_HOLD cycles.
  - At expiry, if the effective mask is nonzero: latch lane_active and go to ALIGN. Otherwise stay in RESET, reload the counter and retry.
  - Effective mask: lane_select, or its lowest set bit only when single_lane=1.
- ALIGN:
  - Active lanes get TX_INIT; inactive lanes get TX_OFF.
  - On simplex_aligned=1: go to BOND if popcount(lane_active)>1, else VERIFY.
- BOND:
  - Active lanes get TX_BOND.
  - On simplex_bonded=1 → VERIFY.
  - simplex_aligned falling → RESET.
- VERIFY:
  - Active lanes get TX_VERIFY; verify_cnt increments each cycle and saturates at VERIFY_MIN.
  - Go to READY when simplex_verified=1 and verify_cnt==VERIFY_MIN. If simplex_verified arrives earlier, keep sending until the count is reached.
  - simplex_aligned falling → RESET.
- READY:
  - Active lanes get TX_DATA; channel_init_finished=1 and axi_ready=1.
  - Loss of simplex_aligned or simplex_verified → RESET. Both flags drop on the next cycle.
- Lane configuration: lane_select and single_lane are sampled only on the RESET→ALIGN transition. Later changes are ignored until the next RESET.
- Counters: the phase counter clears on every state change. Width is $clog2(max(RESET_HOLD, VERIFY_MIN, INIT_TIMEOUT)+1); the counter never wraps.

Optional Feature:
- Macro: AURORA_INIT_WATCHDOG_EN.
- Defined:
  - In ALIGN, BOND and VERIFY, INIT_TIMEOUT cycles without a phase exit pulse init_timeout for 1 cycle and go to RESET.
  - VERIFY timeout applies only when simplex_verified never arrives.
- Undefined: phases wait indefinitely; init_timeout is tied 0; no timeout logic is synthesised.

Decomposition:
- aurora_pkg gains:
  - init_state_t (RESET, ALIGN, BOND, VERIFY, READY).
  - tx_sel_t (TX_OFF, TX_INIT, TX_BOND, TX_VERIFY, TX_DATA).
  - INIT_STATE_W=3, TX_SEL_W=3.
- One sub-module, aurora_lane_mask: combinational single_lane/lowest-set-bit selection plus popcount>1 flag.
- FSM and counters stay in aurora_channel_init_ctrl.

Test Plan:
- Single-lane bring-up:
  - Stimulus: single_lane=1, lane_select=2'b11; aligned at cycle 20, verified at cycle 30.
  - Response: lane_active=2'b01, BOND skipped; READY after 64 VERIFY cycles; channel_init_finished=1.
- Dual-lane:
  - Stimulus: single_lane=0, lane_select=2'b11; aligned, then bonded.
  - Response: BOND visited; both lanes carry TX_BOND, then TX_VERIFY, then TX_DATA.
- Early verify:
  - Stimulus: simplex_verified=1 on the first VERIFY cycle.
  - Response: READY entered exactly 64 cycles after entering VERIFY.
- simplex_reset:
  - Stimulus: pulse simplex_reset in READY, and separately mid-BOND.
  - Response: RESET next cycle; outputs cleared; 16 TX_OFF cycles, then ALIGN.
- Empty mask:
  - Stimulus: lane_select=0.
  - Response: FSM stays in RESET.
  - Stimulus: set 2'b10.
  - Response: ALIGN after the next hold expiry with lane_active=2'b10.
- Watchdog (with AURORA_INIT_WATCHDOG_EN):
  - Stimulus: simplex_aligned held 0.
  - Response: init_timeout pulses after 4096 ALIGN cycles, then RESET.
  - Without the macro: no pulse; FSM stays in ALIGN.
